// File: rtl/mult8x8_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the 8x8 multiplier sequencer and its datapath.
// MULT_CTRL_ABORT_EN adds the abort request line.
interface mult8x8_seq_ctrl_if #(
    parameter int SEL_W = 1,
    parameter int SH_W  = 2
);
    // Input side: a request transfers on any cycle where start & ready are both high.
    // Result side: done stays high until the cycle where done_ack is sampled high.
    logic             start;
    logic             ready;
    logic             load_en;
    logic             acc_clr;
    logic             acc_en;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic [SH_W-1:0]  shift;
    logic             done;
    logic             done_ack;
    logic [1:0]       state_out;
`ifdef MULT_CTRL_ABORT_EN
    logic             abort;

    modport slave (
        input  start, done_ack, abort,
        output ready, load_en, acc_clr, acc_en, sel_a, sel_b, shift, done, state_out
    );
    modport master (
        output start, done_ack, abort,
        input  ready, load_en, acc_clr, acc_en, sel_a, sel_b, shift, done, state_out
    );
`else
    modport slave (
        input  start, done_ack,
        output ready, load_en, acc_clr, acc_en, sel_a, sel_b, shift, done, state_out
    );
    modport master (
        output start, done_ack,
        input  ready, load_en, acc_clr, acc_en, sel_a, sel_b, shift, done, state_out
    );
`endif
endinterface

// File: rtl/mult8x8_seq_ctrl.sv
// Sequencer for the nibble-serial 8x8 multiplier: LOAD, NIB*NIB partial-product steps, DONE.
// Optional abort of an in-flight operation is built when MULT_CTRL_ABORT_EN is defined.
module mult8x8_seq_ctrl #(
    parameter int NIB   = 2,
    parameter int SEL_W = 1,
    parameter int SH_W  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    mult8x8_seq_ctrl_if.slave      bus
);
    localparam int STEPS = NIB * NIB;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(STEPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_req;

`ifdef MULT_CTRL_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_LOAD;
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = abort_req ? S_IDLE : S_CALC;
            end
            S_CALC: begin
                // Abort wins over finishing the last step.
                if (abort_req) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_K) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (bus.done_ack) state_d = bus.start ? S_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Step k walks operand A nibbles fastest: sel_a = k mod NIB, sel_b = k div NIB.
    logic [SEL_W-1:0] k_lo, k_hi;
    assign k_lo = SEL_W'(int'(cnt_q) % NIB);
    assign k_hi = SEL_W'(int'(cnt_q) / NIB);

    logic             load_en_c, acc_clr_c, acc_en_c, done_c;
    logic [SEL_W-1:0] sel_a_c, sel_b_c;
    logic [SH_W-1:0]  shift_c;

    always_comb begin
        load_en_c = 1'b0;
        acc_clr_c = 1'b0;
        acc_en_c  = 1'b0;
        done_c    = 1'b0;
        sel_a_c   = '0;
        sel_b_c   = '0;
        shift_c   = '0;
        case (state_q)
            S_LOAD: begin
                load_en_c = 1'b1;
                acc_clr_c = 1'b1;
            end
            S_CALC: begin
                acc_en_c = ~abort_req;
                sel_a_c  = k_lo;
                sel_b_c  = k_hi;
                shift_c  = SH_W'(k_lo) + SH_W'(k_hi);
            end
            S_DONE:  done_c = 1'b1;
            default: ;
        endcase
    end

    assign bus.ready     = (state_q == S_IDLE) | ((state_q == S_DONE) & bus.done_ack);
    assign bus.load_en   = load_en_c;
    assign bus.acc_clr   = acc_clr_c;
    assign bus.acc_en    = acc_en_c;
    assign bus.sel_a     = sel_a_c;
    assign bus.sel_b     = sel_b_c;
    assign bus.shift     = shift_c;
    assign bus.done      = done_c;
    assign bus.state_out = state_q;
endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Bench for mult8x8_seq_ctrl: scripted vector table, reset/abort sequences, random run vs. model.
// Build with MULT_CTRL_ABORT_EN defined to exercise the abort path as well.
module tb_mult8x8_seq_ctrl;
    localparam int NIB   = 2;
    localparam int STEPS = NIB * NIB;
    localparam int W     = 11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic start_v = 1'b0;
    logic ack_v   = 1'b0;
    logic abort_v = 1'b0;

    mult8x8_seq_ctrl_if #(.SEL_W(1), .SH_W(2)) bus ();
    assign bus.start    = start_v;
    assign bus.done_ack = ack_v;
`ifdef MULT_CTRL_ABORT_EN
    assign bus.abort    = abort_v;
`endif

    mult8x8_seq_ctrl #(.NIB(NIB), .SEL_W(1), .SH_W(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // Observation vector: {state, ready, load_en, acc_clr, acc_en, sel_a, sel_b, shift, done}
    function automatic logic [W-1:0] mk(int st, bit rdy, bit ld, bit clr, bit en,
                                        int sa, int sb, int sh, bit dn);
        logic [1:0] st2 = 2'(st);
        logic [1:0] sh2 = 2'(sh);
        logic       sa1 = 1'(sa);
        logic       sb1 = 1'(sb);
        return {st2, rdy, ld, clr, en, sa1, sb1, sh2, dn};
    endfunction

    function automatic logic [W-1:0] v_idle();            return mk(0, 1, 0, 0, 0, 0, 0, 0, 0); endfunction
    function automatic logic [W-1:0] v_load();            return mk(1, 0, 1, 1, 0, 0, 0, 0, 0); endfunction
    function automatic logic [W-1:0] v_done(bit ack);     return mk(3, ack, 0, 0, 0, 0, 0, 0, 1); endfunction
    function automatic logic [W-1:0] v_calc(int k, bit en);
        return mk(2, 0, 0, 0, en, k % NIB, k / NIB, (k % NIB) + (k / NIB), 0);
    endfunction

    function automatic logic [W-1:0] observe();
        return {bus.state_out, bus.ready, bus.load_en, bus.acc_clr, bus.acc_en,
                bus.sel_a, bus.sel_b, bus.shift, bus.done};
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (state,rdy,ld,clr,en,sa,sb,sh,done)", name, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change on the falling edge; outputs are sampled 1ns later, before the next rising edge.
    task automatic cycle(input logic s, input logic a, input logic ab, output logic [W-1:0] obs);
        @(negedge clk);
        start_v = s;
        ack_v   = a;
        abort_v = ab;
        #1;
        obs = observe();
        @(posedge clk);
    endtask

    task automatic cyc_chk(input string name, input logic s, input logic a, input logic ab,
                           input logic [W-1:0] exp);
        logic [W-1:0] obs;
        cycle(s, a, ab, obs);
        check(name, obs, exp);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         s;
        logic         a;
        logic [W-1:0] exp;
        string        name;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(logic s, logic a, logic [W-1:0] exp, string name);
        vec_t v;
        v.s = s; v.a = a; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endfunction

    // ---------------- reference model ----------------
    // age: -1 idle, 0 loading, 1..STEPS partial-product step age-1, STEPS+1 result held.
    function automatic logic [W-1:0] model_out(int age, bit s, bit a, bit ab);
        if (age < 0)       return v_idle();
        if (age == 0)      return v_load();
        if (age <= STEPS)  return v_calc(age - 1, !ab);
        return v_done(a);
    endfunction

    function automatic int model_next(int age, bit s, bit a, bit ab);
        if (age < 0)                return s ? 0 : -1;
        if (ab && age <= STEPS)     return -1;
        if (age <= STEPS)           return age + 1;
        if (a)                      return s ? 0 : -1;
        return age;
    endfunction

    initial begin
        logic [W-1:0] obs;
        int age;
        bit s, a, ab;

        // Reset state
        #2;
        check("reset_hold", observe(), v_idle());
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) cyc_chk("idle_after_reset", 0, 0, 0, v_idle());

        // Single op with done hold
        add(1, 0, v_idle(), "op_accept");
        add(0, 0, v_load(), "op_load");
        for (int k = 0; k < STEPS; k++) add(0, 0, v_calc(k, 1), "op_calc");
        for (int i = 0; i < 10; i++) add((i % 3) == 0, 0, v_done(0), "done_hold");
        add(0, 1, v_done(1), "done_ack");
        add(0, 0, v_idle(), "idle_after_ack");
        // Back-to-back
        add(1, 0, v_idle(), "b2b_accept");
        add(0, 0, v_load(), "b2b_load1");
        for (int k = 0; k < STEPS; k++) add(0, 0, v_calc(k, 1), "b2b_calc1");
        add(1, 1, v_done(1), "b2b_done_restart");
        add(0, 0, v_load(), "b2b_load2");
        for (int k = 0; k < STEPS; k++) add(0, 0, v_calc(k, 1), "b2b_calc2");
        add(0, 1, v_done(1), "b2b_done_ack");
        add(0, 0, v_idle(), "b2b_idle");
        // Start held high while busy
        add(1, 0, v_idle(), "busy_accept");
        add(1, 0, v_load(), "busy_load");
        for (int k = 0; k < STEPS; k++) add(1, 0, v_calc(k, 1), "busy_calc");
        add(1, 0, v_done(0), "busy_done");
        add(1, 0, v_done(0), "busy_done");
        add(0, 1, v_done(1), "busy_ack");
        add(0, 0, v_idle(), "busy_idle");

        foreach (tbl[i]) cyc_chk(tbl[i].name, tbl[i].s, tbl[i].a, 0, tbl[i].exp);

        // Asynchronous reset in the middle of step k=2
        cycle(1, 0, 0, obs);
        cycle(0, 0, 0, obs);
        cycle(0, 0, 0, obs);
        cycle(0, 0, 0, obs);
        #2;
        check("rst_pre_k2", observe(), v_calc(2, 1));
        reset_n = 1'b0;
        #1;
        check("rst_async", observe(), v_idle());
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) cyc_chk("rst_idle", 0, 0, 0, v_idle());

`ifdef MULT_CTRL_ABORT_EN
        cyc_chk("abt_accept", 1, 0, 0, v_idle());
        cyc_chk("abt_load",   0, 0, 0, v_load());
        cyc_chk("abt_k0",     0, 0, 0, v_calc(0, 1));
        cyc_chk("abt_k1",     0, 0, 1, v_calc(1, 0));
        repeat (3) cyc_chk("abt_idle", 0, 1, 0, v_idle());
        cyc_chk("abt_restart", 1, 0, 0, v_idle());
        cyc_chk("abt_load2",   0, 0, 0, v_load());
        for (int k = 0; k < STEPS; k++) cyc_chk("abt_calc2", 0, 0, 0, v_calc(k, 1));
        cyc_chk("abt_done_noeff", 0, 0, 1, v_done(0));
        cyc_chk("abt_done_ack",   0, 1, 0, v_done(1));
        cyc_chk("abt_idle2",      0, 0, 1, v_idle());
`endif

        // Random run against the model
        age = -1;
        for (int i = 0; i < 400; i++) begin
            s  = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 3) == 0);
`ifdef MULT_CTRL_ABORT_EN
            ab = ($urandom_range(0, 9) == 0);
`else
            ab = 1'b0;
`endif
            exp_q.push_back(model_out(age, s, a, ab));
            cycle(s, a, ab, obs);
            check("random", obs, exp_q.pop_front());
            age = model_next(age, s, a, ab);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult8x8_seq_ctrl.md
Name: mult8x8_seq_ctrl

Overview:
Sequencing controller for the sequential 8x8 multiplier datapath.
- Breaks one 8x8 multiply into NIB*NIB (4) nibble partial products, one 4x4 product per cycle.
- Drives the 4-bit operand nibble muxes (select inputs), the partial-product shift amount, and the accumulator clear/enable.
- Provides a start/ready handshake on the input side and a done/ack handshake on the result side.

Parameters:
- NIB, 2, nibbles per operand; step count = NIB*NIB.
- SEL_W, 1, nibble select width; must equal clog2(NIB).
- SH_W, 2, shift-amount width in nibble units; must hold 2*NIB-2.

Ports:
- clk, in, 1, rising-edge clock.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, request a multiply; accepted when start & ready.
- ready, out, 1, controller can accept start (combinational).
- load_en, out, 1, load operand registers (one-cycle pulse).
- acc_clr, out, 1, clear accumulator (same cycle as load_en).
- acc_en, out, 1, accumulate shifted partial product this cycle.
- sel_a, out, SEL_W, nibble select for operand A mux.
- sel_b, out, SEL_W, nibble select for operand B mux.
- shift, out, SH_W, left shift of partial product, in units of 4 bits.
- done, out, 1, result valid in accumulator; held until acknowledged.
- done_ack, in, 1, consumer has taken the result.
- state_out, out, 2, current state: IDLE=0, LOAD=1, CALC=2, DONE=3.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (async, any state, including mid-operation): state=IDLE, step counter=0.
  - All outputs decode to 0, except ready=1.
- All outputs except ready are Moore-decoded from state and counter. ready = (IDLE) | (DONE & done_ack).
- IDLE:
  - start=1 -> LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - load_en=1, acc_clr=1, acc_en=0; counter<=0.
  - Always -> CALC.
- CALC:
  - acc_en=1 every cycle; counter k runs from 0 to NIB*NIB-1.
  - sel_a = k mod NIB; sel_b = k div NIB; shift = sel_a + sel_b.
  - With NIB=2: k0 (0,0,0), k1 (1,0,1), k2 (0,1,1), k3 (1,1,2).
  - At k = NIB*NIB-1 -> DONE and counter <= 0; otherwise k <= k+1.
- DONE:
  - done=1; acc_en=0; sel_a, sel_b and shift = 0.
  - done_ack=0: stay in DONE.
  - done_ack=1 & start=0 -> IDLE.
  - done_ack=1 & start=1 -> LOAD (back-to-back operation, no IDLE bubble).
- Latency (NIB=2):
  - start accepted at edge T; LOAD during cycle T+1; CALC during T+2..T+5; done=1 from T+6.
  - Total: NIB*NIB+2 cycles from start to done.
- start while in LOAD or CALC is ignored, not queued. start in DONE without done_ack is ignored.
- done_ack outside DONE is ignored.
- state_out encoding is fixed as listed in Ports.
- sel_a, sel_b and shift are 0 in every state except CALC.

Optional Feature:
MULT_CTRL_ABORT_EN
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in LOAD or CALC: acc_en forced to 0 combinationally in that cycle, and state -> IDLE at the next edge with counter <= 0. done is never raised for the aborted operation.
  - abort in IDLE or DONE: no effect.
  - abort has priority over the CALC->DONE transition.
- Undefined: no abort port; the sequence always runs to completion.

Test Plan:
- Reset then idle: reset_n=0 mid-CALC (k=2) -> state_out=0, acc_en=0, done=0, ready=1 immediately (asynchronous). After release, idle cycles keep all outputs at 0 except ready=1.
- Single op: start=1 for one cycle at edge T -> load_en=acc_clr=1 at T+1. At T+2..T+5, (sel_a,sel_b,shift) = (0,0,0),(1,0,1),(0,1,1),(1,1,2) with acc_en=1. done=1 from T+6.
- Done hold: no done_ack for 10 cycles -> done stays 1, ready=0, and start pulses are ignored. done_ack=1 -> IDLE next edge, done=0.
- Back-to-back: done_ack=1 and start=1 in the same DONE cycle -> ready=1 that cycle and LOAD next cycle. No IDLE cycle in between.
- Busy start ignored: start held high throughout CALC -> exactly 4 CALC cycles, then DONE. No restart until done_ack.
- Abort (MULT_CTRL_ABORT_EN defined): abort=1 at k=1 -> acc_en=0 that cycle, IDLE next cycle, done never asserts. A new start then begins with k=0.
